cmp_share_arbiter: RTL

- Shares one registered n-bit magnitude comparator among NREQ requesters.
- Round-robin arbiter grants one requester at a time, captures its operand pair and compares it.
- Returns a one-hot gt/eq/ls result tagged with the requester id.
- Sits between client blocks needing occasional compares and a single comparator datapath, so the compare logic is not replicated per client.

---
 rtl/cmp_share_arbiter_pkg.sv | 11 +
 rtl/cmp_share_arbiter_if.sv | 31 +++
 rtl/cmp_share_arbiter_cmp_core.sv | 18 +
 rtl/cmp_share_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cmp_share_arbiter_pkg.sv
// Shared constants for the comparator-sharing arbiter: FSM encoding and default sizes.
package cmp_share_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEF_BIT  = 4;
  localparam int DEF_NREQ = 4;

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Request/result bundle between client blocks (master) and the shared comparator (slave).
interface cmp_share_arbiter_if
  import cmp_share_arbiter_pkg::*;
#(
  parameter int BIT  = DEF_BIT,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]     req;
  logic [NREQ*BIT-1:0] num1_in;
  logic [NREQ*BIT-1:0] num2_in;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic                res_valid;
  logic [IDW-1:0]      res_id;
  logic                gt;
  logic                eq;
  logic                ls;

  modport master (
    output req, num1_in, num2_in,
    input  grant, busy, res_valid, res_id, gt, eq, ls
  );

  modport slave (
    input  req, num1_in, num2_in,
    output grant, busy, res_valid, res_id, gt, eq, ls
  );

endinterface

// File: rtl/cmp_share_arbiter_cmp_core.sv
// Combinational unsigned magnitude compare; exactly one of gt/eq/ls is set for any input.
module cmp_core
  import cmp_share_arbiter_pkg::*;
#(
  parameter int BIT = DEF_BIT
) (
  input  logic [BIT-1:0] a,
  input  logic [BIT-1:0] b,
  output logic           gt,
  output logic           eq,
  output logic           ls
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign ls = (a < b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter time-sharing one registered comparator among NREQ requesters.
module cmp_share_arbiter
  import cmp_share_arbiter_pkg::*;
#(
  parameter int BIT  = DEF_BIT,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  cmp_share_arbiter_if.slave bus
);

  logic [1:0]      state_reg;
  logic [1:0]      state_next;
  logic [NREQ-1:0] grant_reg;
  logic            busy_reg;
  logic            res_valid_reg;
  logic [IDW-1:0]  res_id_reg;
  logic            gt_reg;
  logic            eq_reg;
  logic            ls_reg;
  logic [IDW-1:0]  last_reg;
  logic [IDW-1:0]  id_reg;
  logic [BIT-1:0]  op_a_reg;
  logic [BIT-1:0]  op_b_reg;

  logic [BIT-1:0]  num1_arr [NREQ];
  logic [BIT-1:0]  num2_arr [NREQ];
  logic [IDW-1:0]  winner_next;
  logic [NREQ-1:0] grant_next;
  logic [IDW:0]    probe;
  logic            cmp_gt;
  logic            cmp_eq;
  logic            cmp_ls;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign num1_arr[gi] = bus.num1_in[gi*BIT +: BIT];
      assign num2_arr[gi] = bus.num2_in[gi*BIT +: BIT];
    end
  endgenerate

  // Scan from farthest to nearest so the requester closest after last_reg wins.
  always_comb begin
    winner_next = last_reg;
    probe       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      probe = {1'b0, last_reg} + (IDW+1)'(k);
      if (probe >= (IDW+1)'(NREQ)) begin
        probe = probe - (IDW+1)'(NREQ);
      end
      if (bus.req[probe[IDW-1:0]]) begin
        winner_next = probe[IDW-1:0];
      end
    end
  end

  assign grant_next = {{(NREQ-1){1'b0}}, 1'b1} << winner_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (|bus.req) state_next = ST_CMP;
      ST_CMP:  state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  cmp_core #(.BIT(BIT)) u_cmp_core (
    .a  (op_a_reg),
    .b  (op_b_reg),
    .gt (cmp_gt),
    .eq (cmp_eq),
    .ls (cmp_ls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      busy_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_id_reg    <= '0;
      gt_reg        <= 1'b0;
      eq_reg        <= 1'b0;
      ls_reg        <= 1'b0;
      last_reg      <= IDW'(NREQ - 1);
      id_reg        <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (|bus.req) begin
            grant_reg <= grant_next;
            op_a_reg  <= num1_arr[winner_next];
            op_b_reg  <= num2_arr[winner_next];
            id_reg    <= winner_next;
            last_reg  <= winner_next;
          end
        end
        ST_CMP: begin
          gt_reg        <= cmp_gt;
          eq_reg        <= cmp_eq;
          ls_reg        <= cmp_ls;
          res_id_reg    <= id_reg;
          res_valid_reg <= 1'b1;
          grant_reg     <= '0;
        end
        ST_RESP: begin
          res_valid_reg <= 1'b0;
        end
        default: begin
          grant_reg     <= '0;
          res_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.busy      = busy_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_id    = res_id_reg;
  assign bus.gt        = gt_reg;
  assign bus.eq        = eq_reg;
  assign bus.ls        = ls_reg;

endmodule
